// File: rtl/wb_uart_pkg.sv
// Shared constants and state encodings for the UART-driven Wishbone initiator.
package wb_uart_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WB_REQ,
        S_WB_WAIT,
        S_TX
    } state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GUARD,
        TX_WAIT
    } tx_state_e;

endpackage

// File: rtl/wb_uart_master_if.sv
// Byte-stream and Wishbone signals of wb_uart_master; master = the block, slave = its environment.
interface wb_uart_master_if;

    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_busy;

    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_wb_stall, i_wb_ack, i_wb_data,
        output o_tx_data, o_tx_valid, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_busy, i_wb_stall, i_wb_ack, i_wb_data,
        input  o_tx_data, o_tx_valid, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel
    );

endinterface

// File: rtl/wb_uart_tx_seq.sv
// Response serializer: sends 1 or 5 bytes of a 40-bit payload MSB first, pacing on tx busy.
module wb_uart_tx_seq
    import wb_uart_pkg::*;
(
    input  logic        i_clk,
    input  logic        in_rst,
    input  logic        start_i,
    input  logic [39:0] payload_i,
    input  logic [2:0]  count_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    tx_state_e   state_q;
    logic [39:0] shift_q;
    logic [2:0]  left_q;

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            left_q     <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            tx_valid_o <= 1'b0;
            done_o     <= 1'b0;
            case (state_q)
                TX_IDLE: if (start_i) begin
                    shift_q <= payload_i;
                    left_q  <= count_i;
                    state_q <= TX_SEND;
                end
                TX_SEND: if (!tx_busy_i) begin
                    tx_valid_o <= 1'b1;
                    tx_data_o  <= shift_q[39:32];
                    shift_q    <= {shift_q[31:0], 8'h00};
                    left_q     <= left_q - 3'd1;
                    state_q    <= TX_GUARD;
                end
                // The bridge raises busy one cycle after the strobe; skip that stale sample.
                TX_GUARD: state_q <= TX_WAIT;
                TX_WAIT: if (!tx_busy_i) begin
                    if (left_q != 3'd0) begin
                        state_q <= TX_SEND;
                    end else begin
                        done_o  <= 1'b1;
                        state_q <= TX_IDLE;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_master.sv
// Parses 'R'/'W' command frames from the UART byte stream and runs each as one Wishbone cycle.
module wb_uart_master
    import wb_uart_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 1024,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic              i_clk,
    input  logic              in_rst,
    wb_uart_master_if.master  bus,
    output logic              o_busy
);

    localparam int AT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam int BT_W = $clog2(BYTE_TIMEOUT) + 1;

    state_e            state_q;
    logic              is_write_q;
    logic [1:0]        byte_idx_q;
    logic [31:0]       addr_sh_q;
    logic [23:0]       data_sh_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              cyc_q;
    logic              stb_q;
    logic [AT_W-1:0]   ack_cnt_q;
    logic [BT_W-1:0]   gap_cnt_q;
    logic              tx_start_q;
    logic [39:0]       tx_payload_q;
    logic [2:0]        tx_count_q;
    logic              tx_done;

    // NOTE: sequential state is assigned with <= only, so every branch reads pre-edge values.
    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= S_IDLE;
            is_write_q   <= 1'b0;
            byte_idx_q   <= '0;
            addr_sh_q    <= '0;
            data_sh_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            ack_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_payload_q <= '0;
            tx_count_q   <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.i_rx_valid && (bus.i_rx_data == OP_READ || bus.i_rx_data == OP_WRITE)) begin
                    is_write_q <= (bus.i_rx_data == OP_WRITE);
                    byte_idx_q <= '0;
                    gap_cnt_q  <= '0;
                    state_q    <= S_ADDR;
                end
                S_ADDR, S_DATA: begin
                    if (bus.i_rx_valid) begin
                        gap_cnt_q  <= '0;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (state_q == S_ADDR) addr_sh_q <= {addr_sh_q[23:0], bus.i_rx_data};
                        else                   data_sh_q <= {data_sh_q[15:0], bus.i_rx_data};
                        if (byte_idx_q == 2'd3) begin
                            if (state_q == S_ADDR && is_write_q) begin
                                state_q <= S_DATA;
                            end else begin
                                // Bus-facing registers load only here so they hold between cycles.
                                if (state_q == S_ADDR) begin
                                    addr_q <= {addr_sh_q[23:0], bus.i_rx_data};
                                end else begin
                                    addr_q  <= addr_sh_q;
                                    wdata_q <= {data_sh_q, bus.i_rx_data};
                                end
                                cyc_q     <= 1'b1;
                                stb_q     <= 1'b1;
                                ack_cnt_q <= '0;
                                state_q   <= S_WB_REQ;
                            end
                        end
                    end else if (gap_cnt_q == BT_W'(BYTE_TIMEOUT - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + BT_W'(1);
                    end
                end
                S_WB_REQ, S_WB_WAIT: begin
                    // Ack wins over the timeout when both land in the same cycle.
                    if (bus.i_wb_ack) begin
                        cyc_q        <= 1'b0;
                        stb_q        <= 1'b0;
                        tx_payload_q <= {RSP_OK, is_write_q ? 32'h0 : bus.i_wb_data};
                        tx_count_q   <= is_write_q ? 3'd1 : 3'd5;
                        tx_start_q   <= 1'b1;
                        state_q      <= S_TX;
                    end else if (ack_cnt_q == AT_W'(ACK_TIMEOUT - 1)) begin
                        cyc_q        <= 1'b0;
                        stb_q        <= 1'b0;
                        tx_payload_q <= {RSP_ERR, 32'h0};
                        tx_count_q   <= 3'd1;
                        tx_start_q   <= 1'b1;
                        state_q      <= S_TX;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + AT_W'(1);
                        if (state_q == S_WB_REQ && !bus.i_wb_stall) begin
                            stb_q   <= 1'b0;
                            state_q <= S_WB_WAIT;
                        end
                    end
                end
                S_TX: if (tx_done) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_wb_cyc  = cyc_q;
    assign bus.o_wb_stb  = stb_q;
    assign bus.o_wb_we   = cyc_q & is_write_q;
    assign bus.o_wb_sel  = {4{cyc_q}};
    assign bus.o_wb_addr = addr_q;
    assign bus.o_wb_data = wdata_q;
    assign o_busy        = (state_q != S_IDLE);

    wb_uart_tx_seq u_tx_seq (
        .i_clk      (i_clk),
        .in_rst     (in_rst),
        .start_i    (tx_start_q),
        .payload_i  (tx_payload_q),
        .count_i    (tx_count_q),
        .tx_busy_i  (bus.i_tx_busy),
        .tx_data_o  (bus.o_tx_data),
        .tx_valid_o (bus.o_tx_valid),
        .done_o     (tx_done)
    );

endmodule

// File: tb/tb_wb_uart_master.sv
// Self-checking bench: random command frames against a frame-level model of bus cycles and responses.
module tb_wb_uart_master;

    localparam int ACK_TO  = 16;
    localparam int BYTE_TO = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    wb_uart_master_if bus ();

    wb_uart_master #(.ACK_TIMEOUT(ACK_TO), .BYTE_TIMEOUT(BYTE_TO)) dut (
        .i_clk  (clk),
        .in_rst (rst_n),
        .bus    (bus),
        .o_busy (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Slave / transmitter environment configuration and observations.
    int          cfg_stall = 0;
    int          cfg_delay = 0;
    bit          cfg_ack_en = 1'b1;
    logic [31:0] cfg_rdata = '0;
    int          cyc_run = 0, stb_run = 0, last_cyc_len = 0, last_stb_len = 0, cyc_done_cnt = 0;
    int          stb_seen = 0, wait_n = 0, busy_left = 0, tx_viol = 0;
    bit          acc = 1'b0, busy_pend = 1'b0, start_busy = 1'b0;
    logic [31:0] snap_addr, snap_data;
    logic        snap_we;
    logic [3:0]  snap_sel;
    logic [7:0]  tx_q[$];

    // Environment sampled and driven at the falling edge, away from the DUT's active edge.
    initial begin
        bus.i_wb_stall = 1'b0;
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_data  = '0;
        bus.i_tx_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_valid) begin
                tx_q.push_back(bus.o_tx_data);
                if (bus.i_tx_busy || busy_pend) tx_viol++;
            end
            start_busy = busy_pend;
            busy_pend  = bus.o_tx_valid;
            if (start_busy) busy_left = $urandom_range(1, 4);
            if (busy_left > 0) begin
                bus.i_tx_busy = 1'b1;
                busy_left--;
            end else begin
                bus.i_tx_busy = 1'b0;
            end

            if (!bus.o_wb_cyc) begin
                if (cyc_run > 0) begin
                    last_cyc_len = cyc_run;
                    last_stb_len = stb_run;
                    cyc_done_cnt++;
                end
                cyc_run = 0; stb_run = 0; acc = 1'b0; stb_seen = 0; wait_n = 0;
                bus.i_wb_ack = 1'b0;
                bus.i_wb_stall = 1'b0;
            end else begin
                cyc_run++;
                if (bus.o_wb_stb) stb_run++;
                if (bus.o_wb_stb && !acc) begin
                    if (stb_seen < cfg_stall) begin
                        bus.i_wb_stall = 1'b1;
                        bus.i_wb_ack   = 1'b0;
                    end else begin
                        bus.i_wb_stall = 1'b0;
                        acc = 1'b1;
                        wait_n = 0;
                        snap_addr = bus.o_wb_addr;
                        snap_data = bus.o_wb_data;
                        snap_we   = bus.o_wb_we;
                        snap_sel  = bus.o_wb_sel;
                        bus.i_wb_ack = cfg_ack_en && (cfg_delay == 0);
                    end
                    stb_seen++;
                end else if (acc) begin
                    bus.i_wb_stall = 1'b0;
                    wait_n++;
                    bus.i_wb_ack = cfg_ack_en && (wait_n == cfg_delay);
                end else begin
                    bus.i_wb_ack = 1'b0;
                end
            end
            bus.i_wb_data = cfg_rdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, expected 0", name, busy, budget);
        end
    endtask

    // One frame end to end; expectations come from the frame rules, not from the DUT.
    task automatic run_frame(input string name, input bit is_wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int stall, input int delay, input bit ack_en);
        logic [7:0] frame[$];
        logic [7:0] exp_tx[$];
        int base, exp_cyc, exp_stb;
        bit ok;
        cfg_stall = stall; cfg_delay = delay; cfg_ack_en = ack_en; cfg_rdata = rdata;
        tx_q.delete();
        tx_viol = 0;
        base = cyc_done_cnt;
        snap_addr = 'x; snap_data = 'x; snap_we = 'x; snap_sel = 'x;

        frame.push_back(is_wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) frame.push_back(addr[8*i +: 8]);
        if (is_wr) for (int i = 3; i >= 0; i--) frame.push_back(wdata[8*i +: 8]);
        foreach (frame[i]) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(frame[i]);
        end
        checks++;
        if (bus.o_wb_cyc !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: cyc=%b one cycle after last byte, expected 1", name, bus.o_wb_cyc);
        end
        wait_idle(name, 300);

        ok      = ack_en && (stall + delay < ACK_TO);
        exp_cyc = ok ? stall + delay + 1 : ACK_TO;
        exp_stb = stall + 1;
        if (ok) begin
            exp_tx.push_back(8'h4B);
            if (!is_wr) for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'h45);
        end

        checks++;
        if (cyc_done_cnt - base !== 1) begin
            errors++;
            $display("FAIL %s_ncyc: got %0d bus cycles, expected 1", name, cyc_done_cnt - base);
        end
        checks++;
        if (last_cyc_len !== exp_cyc) begin
            errors++;
            $display("FAIL %s_cyc_len: got %0d expected %0d", name, last_cyc_len, exp_cyc);
        end
        checks++;
        if (last_stb_len !== exp_stb) begin
            errors++;
            $display("FAIL %s_stb_len: got %0d expected %0d", name, last_stb_len, exp_stb);
        end
        checks++;
        if (snap_addr !== addr || snap_we !== is_wr || snap_sel !== 4'hF) begin
            errors++;
            $display("FAIL %s_req: addr=%h we=%b sel=%h, expected addr=%h we=%b sel=f",
                     name, snap_addr, snap_we, snap_sel, addr, is_wr);
        end
        if (is_wr) begin
            checks++;
            if (snap_data !== wdata) begin
                errors++;
                $display("FAIL %s_wdata: got %h expected %h", name, snap_data, wdata);
            end
        end
        checks++;
        if (tx_q.size() != exp_tx.size()) begin
            errors++;
            $display("FAIL %s_tx_len: got %0d bytes expected %0d", name, tx_q.size(), exp_tx.size());
        end else begin
            foreach (exp_tx[i]) begin
                checks++;
                if (tx_q[i] !== exp_tx[i]) begin
                    errors++;
                    $display("FAIL %s_tx%0d: got %h expected %h", name, i, tx_q[i], exp_tx[i]);
                end
            end
        end
        checks++;
        if (tx_viol != 0) begin
            errors++;
            $display("FAIL %s_tx_pacing: %0d bytes sent while busy, expected 0", name, tx_viol);
        end
    endtask

    task automatic test_reset();
        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_sel, bus.o_tx_valid, busy} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b sel=%h txv=%b busy=%b, expected all 0",
                     bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we, bus.o_wb_sel, bus.o_tx_valid, busy);
        end
        checks++;
        if ({bus.o_wb_addr, bus.o_wb_data, bus.o_tx_data} !== 72'b0) begin
            errors++;
            $display("FAIL reset_data: addr=%h data=%h txd=%h, expected 0",
                     bus.o_wb_addr, bus.o_wb_data, bus.o_tx_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_garbage_partial();
        int base = cyc_done_cnt;
        tx_q.delete();
        send_byte(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL garbage_opcode: busy=%b expected 0", busy);
        end
        send_byte(8'h57);
        send_byte(8'h12);
        repeat (BYTE_TO - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL partial_hold: busy=%b before byte timeout, expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL partial_drop: busy=%b at byte timeout, expected 0", busy);
        end
        checks++;
        if (cyc_done_cnt != base || tx_q.size() != 0) begin
            errors++;
            $display("FAIL garbage_quiet: %0d bus cycles, %0d tx bytes, expected 0 and 0",
                     cyc_done_cnt - base, tx_q.size());
        end
        run_frame("after_garbage", 1'b0, 32'h1000_0004, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b1);
    endtask

    task automatic test_reset_mid_cycle();
        int n = 0;
        cfg_ack_en = 1'b0; cfg_stall = 0; cfg_delay = 0;
        tx_q.delete();
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i));
        while (!(bus.o_wb_cyc && !bus.o_wb_stb) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(bus.o_wb_cyc === 1'b1 && bus.o_wb_stb === 1'b0)) begin
            errors++;
            $display("FAIL rst_mid_reach: cyc=%b stb=%b, expected 1 0", bus.o_wb_cyc, bus.o_wb_stb);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_tx_valid, busy} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_async: cyc=%b stb=%b txv=%b busy=%b, expected 0",
                     bus.o_wb_cyc, bus.o_wb_stb, bus.o_tx_valid, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (tx_q.size() != 0 || busy !== 1'b0 || bus.o_wb_cyc !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_silent: tx bytes=%0d busy=%b cyc=%b, expected 0 0 0",
                     tx_q.size(), busy, bus.o_wb_cyc);
        end
        run_frame("after_reset", 1'b1, 32'hCAFE_0010, 32'h1234_5678, 32'h0, 1, 2, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) != 0));
        end
    endtask

    initial begin
        test_reset();
        run_frame("write", 1'b1, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0, 0, 2, 1'b1);
        run_frame("read_stall", 1'b0, 32'h0000_8000, 32'h0, 32'hDEAD_BEEF, 3, 1, 1'b1);
        run_frame("ack_timeout", 1'b0, 32'h0000_8000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        test_garbage_partial();
        run_frame("same_cycle_ack", 1'b0, 32'h2000_0000, 32'h0, 32'h5A5A_A5A5, 0, 0, 1'b1);
        run_frame("same_cycle_wr", 1'b1, 32'h2000_0008, 32'h0F0F_F0F0, 32'h0, 0, 0, 1'b1);
        test_reset_mid_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
